// File: rtl/ulpi_tx_arbiter.sv
// Round-robin arbiter sharing the ULPI TX engine between register-write and packet requesters.
// Optional statistics counters are built when ULPI_ARB_STATS_EN is defined.
module ulpi_tx_arbiter #(
  parameter int TURN_CYCLES = 2,
  parameter int TIMEOUT     = 1023,
  parameter int MAX_RETRY   = 3
`ifdef ULPI_ARB_STATS_EN
  ,
  parameter int STAT_W      = 16
`endif
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req_reg,
  input  logic              req_pkt,
  input  logic              dir,
  input  logic              tx_done,
  input  logic              tx_abort,
  output logic              gnt_reg,
  output logic              gnt_pkt,
  output logic              tx_start,
  output logic              tx_sel,
`ifdef ULPI_ARB_STATS_EN
  output logic [STAT_W-1:0] cnt_reg,
  output logic [STAT_W-1:0] cnt_pkt,
  output logic [STAT_W-1:0] cnt_err,
`endif
  output logic              err
);

  localparam int TURN_W  = $clog2(TURN_CYCLES + 2);
  localparam int TIMER_W = $clog2(TIMEOUT + 2);
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    HOLD,
    RELEASE,
    ERR
  } state_t;

  state_t               state_q, state_d;
  logic                 gnt_reg_q, gnt_reg_d;
  logic                 gnt_pkt_q, gnt_pkt_d;
  logic                 tx_sel_q, tx_sel_d;
  logic                 rr_ptr_q, rr_ptr_d;
  logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [TURN_W-1:0]    turn_cnt_q, turn_cnt_d;
  logic                 bus_free;
  logic                 pick_pkt;

  assign bus_free = !dir && (turn_cnt_q == '0);
  // A lone requester always wins; on contention rr_ptr names the side whose turn it is.
  assign pick_pkt = req_pkt && (!req_reg || rr_ptr_q);

  always_comb begin
    state_d     = state_q;
    gnt_reg_d   = gnt_reg_q;
    gnt_pkt_d   = gnt_pkt_q;
    tx_sel_d    = tx_sel_q;
    rr_ptr_d    = rr_ptr_q;
    retry_cnt_d = retry_cnt_q;
    timer_d     = timer_q;
    turn_cnt_d  = turn_cnt_q;

    if (dir) begin
      turn_cnt_d = TURN_W'(TURN_CYCLES);
    end else if (turn_cnt_q != '0) begin
      turn_cnt_d = turn_cnt_q - 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus_free && (req_reg || req_pkt)) begin
          gnt_pkt_d   = pick_pkt;
          gnt_reg_d   = !pick_pkt;
          tx_sel_d    = pick_pkt;
          retry_cnt_d = '0;
          state_d     = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (tx_done) begin
          gnt_reg_d = 1'b0;
          gnt_pkt_d = 1'b0;
          state_d   = RELEASE;
        end else if (tx_abort && (retry_cnt_q < RETRY_W'(MAX_RETRY))) begin
          retry_cnt_d = retry_cnt_q + 1'b1;
          state_d     = HOLD;
        end else if (tx_abort || (timer_q == TIMER_W'(TIMEOUT))) begin
          gnt_reg_d = 1'b0;
          gnt_pkt_d = 1'b0;
          state_d   = ERR;
        end
      end
      HOLD: begin
        if (bus_free) begin
          state_d = START;
        end
      end
      RELEASE, ERR: begin
        rr_ptr_d = !tx_sel_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      gnt_reg_q   <= 1'b0;
      gnt_pkt_q   <= 1'b0;
      tx_sel_q    <= 1'b0;
      rr_ptr_q    <= 1'b0;
      retry_cnt_q <= '0;
      timer_q     <= '0;
      turn_cnt_q  <= TURN_W'(TURN_CYCLES);
    end else begin
      state_q     <= state_d;
      gnt_reg_q   <= gnt_reg_d;
      gnt_pkt_q   <= gnt_pkt_d;
      tx_sel_q    <= tx_sel_d;
      rr_ptr_q    <= rr_ptr_d;
      retry_cnt_q <= retry_cnt_d;
      timer_q     <= timer_d;
      turn_cnt_q  <= turn_cnt_d;
    end
  end

  assign gnt_reg  = gnt_reg_q;
  assign gnt_pkt  = gnt_pkt_q;
  assign tx_sel   = tx_sel_q;
  assign tx_start = (state_q == START);
  assign err      = (state_q == ERR);

`ifdef ULPI_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_reg_q, cnt_reg_d;
  logic [STAT_W-1:0] cnt_pkt_q, cnt_pkt_d;
  logic [STAT_W-1:0] cnt_err_q, cnt_err_d;

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    cnt_reg_d = cnt_reg_q;
    cnt_pkt_d = cnt_pkt_q;
    cnt_err_d = cnt_err_q;
    if (state_q == RELEASE) begin
      if (tx_sel_q) begin
        if (cnt_pkt_q != '1) cnt_pkt_d = cnt_pkt_q + 1'b1;
      end else begin
        if (cnt_reg_q != '1) cnt_reg_d = cnt_reg_q + 1'b1;
      end
    end
    if ((state_q == ERR) && (cnt_err_q != '1)) begin
      cnt_err_d = cnt_err_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_reg_q <= '0;
      cnt_pkt_q <= '0;
      cnt_err_q <= '0;
    end else begin
      cnt_reg_q <= cnt_reg_d;
      cnt_pkt_q <= cnt_pkt_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  assign cnt_reg = cnt_reg_q;
  assign cnt_pkt = cnt_pkt_q;
  assign cnt_err = cnt_err_q;
`endif

endmodule

// File: tb/tb_ulpi_tx_arbiter.sv
// Self-checking bench for ulpi_tx_arbiter; each expected tx_start pulse carries its expected source in a scoreboard queue.
// Statistics checks are compiled in when ULPI_ARB_STATS_EN is defined.
module tb_ulpi_tx_arbiter;

  localparam int TURN_CYCLES = 2;
  localparam int TIMEOUT     = 1023;

  logic clk;
  logic nRst;
  logic reqReg;
  logic reqPkt;
  logic dirIn;
  logic txDone;
  logic txAbort;
  logic gntReg;
  logic gntPkt;
  logic txStart;
  logic txSel;
  logic errOut;
`ifdef ULPI_ARB_STATS_EN
  logic [1:0] cntReg;
  logic [1:0] cntPkt;
  logic [1:0] cntErr;
`endif

  int checkCount = 0;
  int errorCount = 0;
  int errPulses  = 0;
  int startCount = 0;
  logic prevStart = 1'b0;
  logic expSel[$];

`ifdef ULPI_ARB_STATS_EN
  ulpi_tx_arbiter #(.STAT_W(2)) dut (
`else
  ulpi_tx_arbiter dut (
`endif
    .clk     (clk),
    .n_rst   (nRst),
    .req_reg (reqReg),
    .req_pkt (reqPkt),
    .dir     (dirIn),
    .tx_done (txDone),
    .tx_abort(txAbort),
    .gnt_reg (gntReg),
    .gnt_pkt (gntPkt),
    .tx_start(txStart),
    .tx_sel  (txSel),
`ifdef ULPI_ARB_STATS_EN
    .cnt_reg (cntReg),
    .cnt_pkt (cntPkt),
    .cnt_err (cntErr),
`endif
    .err     (errOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Scoreboard side: every tx_start pulse must match the next queued expected source.
  always @(negedge clk) begin
    if (nRst) begin
      if (gntReg || gntPkt) checkOutput("gnt_exclusive", 32'(gntReg & gntPkt), 0);
      if (errOut) errPulses++;
      if (txStart) begin
        startCount++;
        checkOutput("start_pulse_width", 32'(prevStart), 0);
        if (expSel.size() == 0) begin
          checkOutput("unexpected_start", 1, 0);
        end else begin
          logic e;
          e = expSel.pop_front();
          checkOutput("start_sel", 32'(txSel), 32'(e));
          checkOutput("start_gnt", 32'(e ? gntPkt : gntReg), 1);
        end
      end
      prevStart = txStart;
    end else begin
      prevStart = 1'b0;
    end
  end

  task automatic applyStimulus(input logic r, input logic p, input logic d);
    reqReg = r;
    reqPkt = p;
    dirIn  = d;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic done, input logic abort);
    txDone  = done;
    txAbort = abort;
    stepCycles(1);
    txDone  = 1'b0;
    txAbort = 1'b0;
  endtask

  task automatic waitForStart(input string tag, output int n);
    n = 0;
    do begin
      stepCycles(1);
      n++;
    end while (!txStart && n < 2000);
    if (!txStart) checkOutput({tag, "_start_timeout"}, 0, 1);
  endtask

  task automatic waitForErr(input string tag, output int n);
    n = 0;
    do begin
      stepCycles(1);
      n++;
    end while (!errOut && n < 1100);
    if (!errOut) checkOutput({tag, "_err_timeout"}, 0, 1);
  endtask

  task automatic resetDut();
    nRst = 1'b0;
    #1;
    checkOutput("rst_gnt_reg", 32'(gntReg), 0);
    checkOutput("rst_gnt_pkt", 32'(gntPkt), 0);
    checkOutput("rst_tx_start", 32'(txStart), 0);
    checkOutput("rst_tx_sel", 32'(txSel), 0);
    checkOutput("rst_err", 32'(errOut), 0);
`ifdef ULPI_ARB_STATS_EN
    checkOutput("rst_cnt_reg", 32'(cntReg), 0);
    checkOutput("rst_cnt_err", 32'(cntErr), 0);
`endif
    stepCycles(2);
    @(negedge clk);
    nRst = 1'b1;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int base;
    nRst    = 1'b0;
    txDone  = 1'b0;
    txAbort = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset release with REG requesting: turnaround counter holds off tx_start for two cycles.
    applyStimulus(1'b1, 1'b0, 1'b0);
    resetDut();
    expSel.push_back(1'b0);
    stepCycles(1);
    checkOutput("s1_turn_1", 32'(txStart), 0);
    stepCycles(1);
    checkOutput("s1_turn_0", 32'(txStart), 0);
    stepCycles(1);
    checkOutput("s1_start", 32'(txStart), 1);
    checkOutput("s1_gnt_reg", 32'(gntReg), 1);
    checkOutput("s1_tx_sel", 32'(txSel), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycles(1);
    checkOutput("s1_start_done", 32'(txStart), 0);
    stepCycles(4);
    pulse(1'b1, 1'b0);
    checkOutput("s1_release_gnt", 32'(gntReg), 0);

    // Both requesters held: strict alternation from reset, REG first.
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b0);
    expSel.push_back(1'b0);
    expSel.push_back(1'b1);
    expSel.push_back(1'b0);
    expSel.push_back(1'b1);
    for (int i = 0; i < 4; i++) begin
      waitForStart("s2", n);
      if (i > 0) checkOutput("s2_regrant_gap", n, 2);
      stepCycles(5);
      pulse(1'b1, 1'b0);
      if (i == 3) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("s2_release_gnt", 32'(gntReg | gntPkt), 0);
    end

    // Three aborts then done: four attempts, grant held, no error.
    base = errPulses;
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (4) expSel.push_back(1'b1);
    for (int i = 0; i < 4; i++) begin
      waitForStart("s3", n);
      if (i == 0) applyStimulus(1'b0, 1'b0, 1'b0);
      else checkOutput("s3_retry_gap", n, 1);
      checkOutput("s3_gnt_start", 32'(gntPkt), 1);
      stepCycles(3);
      checkOutput("s3_gnt_wait", 32'(gntPkt), 1);
      pulse(i == 3, i < 3);
      if (i < 3) checkOutput("s3_gnt_hold", 32'(gntPkt), 1);
    end
    checkOutput("s3_release_gnt", 32'(gntPkt), 0);
    stepCycles(2);
    checkOutput("s3_no_err", errPulses - base, 0);

    // Four aborts: retries exhausted, single err pulse.
    base = errPulses;
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (4) expSel.push_back(1'b1);
    for (int i = 0; i < 4; i++) begin
      waitForStart("s3b", n);
      if (i == 0) applyStimulus(1'b0, 1'b0, 1'b0);
      stepCycles(3);
      pulse(1'b0, 1'b1);
      checkOutput("s3b_err_level", 32'(errOut), (i == 3) ? 1 : 0);
    end
    checkOutput("s3b_err_gnt", 32'(gntPkt), 0);
    stepCycles(3);
    checkOutput("s3b_err_once", errPulses - base, 1);

    // Hung engine: WAIT spans timer 0..TIMEOUT, err the cycle after; next grant flips side.
    applyStimulus(1'b1, 1'b0, 1'b0);
    expSel.push_back(1'b0);
    waitForStart("s4", n);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitForErr("s4", n);
    checkOutput("s4_timeout_cycles", n, TIMEOUT + 2);
    checkOutput("s4_gnt_drop", 32'(gntReg | gntPkt), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    expSel.push_back(1'b1);
    waitForStart("s4_next", n);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycles(2);
    pulse(1'b1, 1'b0);

    // PHY owns the bus: no grant; counting the dir-fall cycle as 1, tx_start lands in cycle TURN_CYCLES+2.
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepCycles(10);
    checkOutput("s5_blocked_gnt", 32'(gntPkt), 0);
    expSel.push_back(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    n = 1;
    while (!txStart && n < 50) begin
      stepCycles(1);
      n++;
    end
    checkOutput("s5_dir_to_start", n, TURN_CYCLES + 2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycles(2);
    base = errPulses;
    n = startCount;
    pulse(1'b1, 1'b1);
    checkOutput("s5_done_wins_gnt", 32'(gntPkt), 0);
    stepCycles(6);
    checkOutput("s5_no_retry", startCount - n, 0);
    checkOutput("s5_no_err", errPulses - base, 0);

    // Reset in the middle of a transfer.
    applyStimulus(1'b1, 1'b0, 1'b0);
    expSel.push_back(1'b0);
    waitForStart("s6", n);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycles(2);
    resetDut();
    stepCycles(4);
    checkOutput("s6_idle_after_rst", 32'(gntReg | txStart), 0);

`ifdef ULPI_ARB_STATS_EN
    // Two-bit counters saturate at 3.
    resetDut();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      expSel.push_back(1'b0);
      waitForStart("st", n);
      applyStimulus(1'b0, 1'b0, 1'b0);
      stepCycles(2);
      pulse(1'b1, 1'b0);
    end
    stepCycles(1);
    checkOutput("st_cnt_reg_sat", 32'(cntReg), 3);
    checkOutput("st_cnt_pkt", 32'(cntPkt), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    expSel.push_back(1'b1);
    waitForStart("st_to", n);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitForErr("st_to", n);
    stepCycles(1);
    checkOutput("st_cnt_err", 32'(cntErr), 1);
`endif

    stepCycles(2);
    checkOutput("sb_queue_empty", expSel.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
